// File: rtl/accum_int_tree.sv
// rtl/accum_int_tree.sv - multi-lane integer accumulate unit with a registered radix-R adder tree
// Lanes are masked and extended, reduced over K registered tree levels, then combined with the running accumulator.
module accum_int_tree #(
   parameter int W     = 64,
   parameter int N     = 108,
   parameter int R     = 4,
   parameter int TAG_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N-1:0][W-1:0]   B,
   input  logic [N-1:0]          lane_en,
   input  logic                  din_en,
   input  logic                  sgn,
   input  logic                  acc,
   input  logic                  sat,
   input  logic [TAG_W-1:0]      tag,
   input  logic                  clr,
   output logic [W:0]            res,
   output logic                  res_en,
   output logic                  res_vld,
   output logic [TAG_W-1:0]      res_tag,
   output logic                  res_ovf
);

   function automatic int tree_levels(int n, int r);
      int k;
      int c;
      k = 0;
      c = 1;
      while (c < n) begin
         c = c * r;
         k++;
      end
      return k;
   endfunction

   localparam int K  = tree_levels(N, R);
   localparam int GW = W + 2 + $clog2(N);
   localparam int NP = ((N + R - 1) / R) * R;

   // Level 0 is the input register; slots past the live node count always hold zero.
   logic [GW-1:0]    tree [0:K][0:NP-1];
   logic [GW-1:0]    nxt  [0:K][0:NP-1];
   logic [K:0]       vld;
   logic [K:0]       p_sgn;
   logic [K:0]       p_acc;
   logic [K:0]       p_sat;
   logic [TAG_W-1:0] p_tag [0:K];

   logic [W:0]       acc_q;
   logic [W:0]       res_q;
   logic [GW-1:0]    acc_ext;
   logic [GW-1:0]    sum;
   logic [W:0]       sat_val;
   logic [W:0]       result;
   logic             ovf;

   always_comb begin
      for (int j = 0; j < NP; j++) begin
         nxt[0][j] = '0;
         if (j < N && lane_en[j]) begin
            if (sgn) nxt[0][j] = {{(GW-W){B[j][W-1]}}, B[j]};
            else     nxt[0][j] = {{(GW-W){1'b0}}, B[j]};
         end
      end
      for (int l = 1; l <= K; l++) begin
         for (int j = 0; j < NP; j++) begin
            nxt[l][j] = '0;
            for (int i = 0; i < R; i++) begin
               if (j * R + i < NP) nxt[l][j] = nxt[l][j] + tree[l-1][j*R+i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int l = 0; l <= K; l++) begin
         for (int j = 0; j < NP; j++) tree[l][j] <= nxt[l][j];
      end
      p_sgn    <= {p_sgn[K-1:0], sgn};
      p_acc    <= {p_acc[K-1:0], acc};
      p_sat    <= {p_sat[K-1:0], sat};
      p_tag[0] <= tag;
      for (int l = 1; l <= K; l++) p_tag[l] <= p_tag[l-1];
      if (rst) vld <= '0;
      else     vld <= {vld[K-1:0], din_en};
   end

   // clr overrides the accumulator operand in the same cycle so the op sees zero.
   always_comb begin
      acc_ext = p_sgn[K] ? {{(GW-W-1){acc_q[W]}}, acc_q} : {{(GW-W-1){1'b0}}, acc_q};
      sum     = tree[K][0] + ((p_acc[K] && !clr) ? acc_ext : '0);
      if (p_sgn[K]) begin
         ovf     = (sum[GW-1:W] != '0) && (sum[GW-1:W] != '1);
         sat_val = sum[GW-1] ? {1'b1, {W{1'b0}}} : {1'b0, {W{1'b1}}};
      end else begin
         ovf     = (sum[GW-1:W+1] != '0);
         sat_val = '1;
      end
      result = (p_sat[K] && ovf) ? sat_val : sum[W:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         res_vld <= 1'b0;
         res_tag <= '0;
         res_ovf <= 1'b0;
         res_q   <= '0;
         acc_q   <= '0;
      end else begin
         res_vld <= vld[K];
         if (vld[K]) begin
            res_q   <= result;
            res_tag <= p_tag[K];
            res_ovf <= ovf;
            acc_q   <= result;
         end else if (clr) begin
            acc_q <= '0;
         end
      end
   end

   assign res_en = vld[K];
   assign res    = res_vld ? res_q : 'z;

endmodule

// File: tb/tb_accum_int_tree.sv
// tb/tb_accum_int_tree.sv - directed self-checking bench for accum_int_tree
module tb_accum_int_tree;
   localparam int W     = 64;
   localparam int N     = 108;
   localparam int R     = 4;
   localparam int TAG_W = 8;

   logic                clk = 1'b0;
   logic                rst;
   logic [N-1:0][W-1:0] b;
   logic [N-1:0]        lane_en;
   logic                din_en, sgn, acc, sat, clr;
   logic [TAG_W-1:0]    tag;
   logic [W:0]          res;
   logic                res_en, res_vld, res_ovf;
   logic [TAG_W-1:0]    res_tag;

   logic [W:0] zz;
   int n_checks = 0;
   int n_fail   = 0;

   accum_int_tree #(.W(W), .N(N), .R(R), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .B(b), .lane_en(lane_en), .din_en(din_en),
      .sgn(sgn), .acc(acc), .sat(sat), .tag(tag), .clr(clr),
      .res(res), .res_en(res_en), .res_vld(res_vld), .res_tag(res_tag), .res_ovf(res_ovf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic issue(input logic [W-1:0] v, input logic s, input logic a,
                        input logic st, input logic [TAG_W-1:0] tg);
      for (int i = 0; i < N; i++) b[i] = v;
      lane_en = '1;
      din_en  = 1'b1;
      sgn     = s;
      acc     = a;
      sat     = st;
      tag     = tg;
   endtask

   task automatic idle();
      din_en = 1'b0;
      acc    = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      n_checks++;
      if (res_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b expected 0", res_vld); end
      n_checks++;
      if (res_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b expected 0", res_en); end
      n_checks++;
      if (res !== zz) begin n_fail++; $display("FAIL reset_res: got %h expected z", res); end
      n_checks++;
      if (res_tag !== 8'h00 || res_ovf !== 1'b0) begin
         n_fail++; $display("FAIL reset_tag_ovf: got %h/%b expected 00/0", res_tag, res_ovf);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      issue(64'd1, 1'b0, 1'b0, 1'b0, 8'h3C);
      tick();
      idle();
      for (int c = 1; c < 5; c++) begin
         n_checks++;
         if (res_en !== 1'b0) begin n_fail++; $display("FAIL basic_early_en t+%0d: got %b expected 0", c, res_en); end
         tick();
      end
      n_checks++;
      if (res_en !== 1'b1 || res_vld !== 1'b0) begin
         n_fail++; $display("FAIL basic_en: got en=%b vld=%b expected en=1 vld=0", res_en, res_vld);
      end
      tick();
      n_checks++;
      if (res_vld !== 1'b1 || res !== 65'd108) begin
         n_fail++; $display("FAIL basic_res: got vld=%b res=%h expected vld=1 res=%h", res_vld, res, 65'd108);
      end
      n_checks++;
      if (res_tag !== 8'h3C || res_ovf !== 1'b0) begin
         n_fail++; $display("FAIL basic_tag_ovf: got %h/%b expected 3c/0", res_tag, res_ovf);
      end
      tick();
      n_checks++;
      if (res !== zz || res_vld !== 1'b0) begin
         n_fail++; $display("FAIL basic_release: got vld=%b res=%h expected vld=0 res=z", res_vld, res);
      end
   endtask

   task automatic test_all_ones();
      logic [W:0] exp_res [4];
      logic       exp_ovf [4];
      exp_res[0] = 65'h1_FFFF_FFFF_FFFF_FF94; exp_ovf[0] = 1'b0;
      exp_res[1] = 65'h1_FFFF_FFFF_FFFF_FF94; exp_ovf[1] = 1'b1;
      exp_res[2] = 65'h1_FFFF_FFFF_FFFF_FFFF; exp_ovf[2] = 1'b1;
      exp_res[3] = 65'h1_0000_0000_0000_0000; exp_ovf[3] = 1'b1;
      issue(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 8'hA0); tick();
      issue(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 8'hA1); tick();
      issue(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 8'hA2); tick();
      issue(64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 8'hA3); tick();
      idle();
      tick(); tick();
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (res_vld !== 1'b1 || res !== exp_res[k] || res_ovf !== exp_ovf[k] || res_tag !== 8'hA0 + 8'(k)) begin
            n_fail++;
            $display("FAIL all_ones op%0d: got vld=%b res=%h ovf=%b tag=%h expected vld=1 res=%h ovf=%b tag=%h",
                     k, res_vld, res, res_ovf, res_tag, exp_res[k], exp_ovf[k], 8'hA0 + 8'(k));
         end
         tick();
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [W:0] exp_res [3];
      exp_res[0] = 65'd216; exp_res[1] = 65'd432; exp_res[2] = 65'd648;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int k = 0; k < 3; k++) begin
         issue(64'd2, 1'b0, 1'b1, 1'b0, 8'hB0 + 8'(k));
         tick();
      end
      idle();
      repeat (3) tick();
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (res_vld !== 1'b1 || res !== exp_res[k]) begin
            n_fail++; $display("FAIL b2b op%0d: got vld=%b res=%h expected vld=1 res=%h", k, res_vld, res, exp_res[k]);
         end
         tick();
      end
   endtask

   task automatic test_clr_priority();
      issue(64'd1, 1'b0, 1'b1, 1'b0, 8'hC1); tick();
      issue(64'd1, 1'b0, 1'b1, 1'b0, 8'hC2); tick();
      idle();
      repeat (3) tick();
      n_checks++;
      if (res_en !== 1'b1) begin n_fail++; $display("FAIL clr_en: got %b expected 1", res_en); end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      n_checks++;
      if (res_vld !== 1'b1 || res !== 65'd108 || res_tag !== 8'hC1) begin
         n_fail++; $display("FAIL clr_first: got vld=%b res=%h tag=%h expected 1/%h/c1", res_vld, res, res_tag, 65'd108);
      end
      tick();
      n_checks++;
      if (res_vld !== 1'b1 || res !== 65'd216 || res_tag !== 8'hC2) begin
         n_fail++; $display("FAIL clr_second: got vld=%b res=%h tag=%h expected 1/%h/c2", res_vld, res, res_tag, 65'd216);
      end
      tick();
   endtask

   task automatic test_lane_mask();
      issue(64'hDEAD, 1'b0, 1'b0, 1'b0, 8'hD1);
      lane_en      = '0;
      lane_en[0]   = 1'b1;
      lane_en[107] = 1'b1;
      b[0]         = 64'd5;
      b[107]       = 64'd7;
      tick();
      idle();
      lane_en = '1;
      repeat (5) tick();
      n_checks++;
      if (res_vld !== 1'b1 || res !== 65'd12 || res_ovf !== 1'b0) begin
         n_fail++; $display("FAIL lane_mask: got vld=%b res=%h ovf=%b expected 1/%h/0", res_vld, res, res_ovf, 65'd12);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      logic seen_vld;
      logic seen_drive;
      seen_vld   = 1'b0;
      seen_drive = 1'b0;
      issue(64'd1, 1'b0, 1'b1, 1'b0, 8'hE1); tick();
      issue(64'd1, 1'b0, 1'b1, 1'b0, 8'hE2); tick();
      idle();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (res_vld !== 1'b0) seen_vld = 1'b1;
         if (res !== zz) seen_drive = 1'b1;
         tick();
      end
      n_checks++;
      if (seen_vld !== 1'b0) begin n_fail++; $display("FAIL rst_mid_vld: got %b expected 0", seen_vld); end
      n_checks++;
      if (seen_drive !== 1'b0) begin n_fail++; $display("FAIL rst_mid_res: got driven=%b expected 0", seen_drive); end
      issue(64'd1, 1'b0, 1'b1, 1'b0, 8'hE3);
      tick();
      idle();
      repeat (5) tick();
      n_checks++;
      if (res_vld !== 1'b1 || res !== 65'd108 || res_tag !== 8'hE3) begin
         n_fail++; $display("FAIL rst_post: got vld=%b res=%h tag=%h expected 1/%h/e3", res_vld, res, res_tag, 65'd108);
      end
      tick();
   endtask

   initial begin
      zz      = 'z;
      rst     = 1'b1;
      clr     = 1'b0;
      din_en  = 1'b0;
      sgn     = 1'b0;
      acc     = 1'b0;
      sat     = 1'b0;
      tag     = '0;
      lane_en = '1;
      b       = '0;
      test_reset();
      test_basic();
      test_all_ones();
      test_back_to_back();
      test_clr_priority();
      test_lane_mask();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
